// File: rtl/vga_text_scanout.sv
// VGA text-mode read side: timing counters, scroll-wrapped text-buffer addressing,
// font-ROM glyph fetch and a 3-stage pixel pipeline with aligned syncs.
module vga_text_scanout #(
    parameter int h_disp  = 1280,
    parameter int h_front = 48,
    parameter int h_sync  = 112,
    parameter int h_back  = 248,
    parameter int v_disp  = 1024,
    parameter int v_front = 1,
    parameter int v_sync  = 3,
    parameter int v_back  = 38,
    localparam int x_limit    = h_disp / 8,
    localparam int y_limit    = v_disp / 8,
    localparam int addr_limit = x_limit * y_limit,
    localparam int addr_width = $clog2(addr_limit)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [addr_width-1:0] addr_init,
    output logic [addr_width-1:0] addr_read,
    input  logic [7:0]            char_read,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_row,
    output logic                  pixel,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam int h_total = h_disp + h_front + h_sync + h_back;
    localparam int v_total = v_disp + v_front + v_sync + v_back;
    localparam int xw      = $clog2(h_total);
    localparam int yw      = $clog2(v_total);
    localparam int aw      = addr_width;

    localparam logic [xw-1:0] x_last = xw'(h_total - 1);
    localparam logic [xw-1:0] x_vis  = xw'(h_disp);
    localparam logic [xw-1:0] hs_on  = xw'(h_disp + h_front);
    localparam logic [xw-1:0] hs_off = xw'(h_disp + h_front + h_sync);
    localparam logic [yw-1:0] y_last = yw'(v_total - 1);
    localparam logic [yw-1:0] y_vis  = yw'(v_disp);
    localparam logic [yw-1:0] vs_on  = yw'(v_disp + v_front);
    localparam logic [yw-1:0] vs_off = yw'(v_disp + v_front + v_sync);
    localparam logic [aw:0]   lim    = (aw + 1)'(addr_limit);
    localparam logic [aw:0]   row_step = (aw + 1)'(x_limit);

    logic [xw-1:0] x_reg;
    logic [yw-1:0] y_reg;
    // Wrapped address of column 0 of the current character row; on row 0 it is the scroll origin.
    logic [aw-1:0] row_base_reg;

    logic          visible;
    logic          hs_s0;
    logic          vs_s0;
    logic          fs_s0;
    logic [aw:0]   row_sum;
    logic [aw:0]   cell_sum;
    logic [aw-1:0] row_next;
    logic [aw-1:0] cell_addr;

    always_comb begin
        visible   = (x_reg < x_vis) && (y_reg < y_vis);
        hs_s0     = (x_reg >= hs_on) && (x_reg < hs_off);
        vs_s0     = (y_reg >= vs_on) && (y_reg < vs_off);
        fs_s0     = (x_reg == '0) && (y_reg == '0);
        // Both operands are below addr_limit, so one conditional subtract completes the wrap.
        row_sum   = {1'b0, row_base_reg} + row_step;
        row_next  = (row_sum >= lim) ? aw'(row_sum - lim) : row_sum[aw-1:0];
        cell_sum  = {1'b0, row_base_reg} + (aw + 1)'(x_reg[xw-1:3]);
        cell_addr = (cell_sum >= lim) ? aw'(cell_sum - lim) : cell_sum[aw-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            row_base_reg <= '0;
        end else if (x_reg == x_last) begin
            x_reg <= '0;
            if (y_reg == y_last) begin
                // Origin is only taken between frames so a scroll never tears the picture.
                y_reg        <= '0;
                row_base_reg <= addr_init;
            end else begin
                y_reg <= y_reg + 1'b1;
                if (y_reg[2:0] == 3'd7) begin
                    row_base_reg <= row_next;
                end
            end
        end else begin
            x_reg <= x_reg + 1'b1;
        end
    end

    // ctrl bundles are {frame_start, vsync, hsync, de} travelling alongside the pixel data.
    logic [2:0] y_lo_s1_reg;
    logic [2:0] x_lo_s1_reg;
    logic [3:0] ctrl_s1_reg;
    logic [2:0] x_lo_s2_reg;
    logic [3:0] ctrl_s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_read   <= '0;
            y_lo_s1_reg <= '0;
            x_lo_s1_reg <= '0;
            ctrl_s1_reg <= '0;
            font_addr   <= '0;
            x_lo_s2_reg <= '0;
            ctrl_s2_reg <= '0;
            pixel       <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (visible) begin
                addr_read <= cell_addr;
            end
            y_lo_s1_reg <= y_reg[2:0];
            x_lo_s1_reg <= x_reg[2:0];
            ctrl_s1_reg <= {fs_s0, vs_s0, hs_s0, visible};

            font_addr   <= {char_read, y_lo_s1_reg};
            x_lo_s2_reg <= x_lo_s1_reg;
            ctrl_s2_reg <= ctrl_s1_reg;

            pixel       <= font_row[3'd7 - x_lo_s2_reg] & ctrl_s2_reg[0];
            de          <= ctrl_s2_reg[0];
            hsync       <= ctrl_s2_reg[1];
            vsync       <= ctrl_s2_reg[2];
            frame_start <= ctrl_s2_reg[3];
        end
    end

endmodule

// File: tb/tb_vga_text_scanout.sv
// Bench for vga_text_scanout: a 16x16 instance checked cycle by cycle against an arithmetic
// screen model, plus a default-size instance checked over its first visible lines.
module tb_vga_text_scanout;

    localparam int SH    = 16;
    localparam int SV    = 16;
    localparam int SFP   = 2;
    localparam int SSY   = 2;
    localparam int SBP   = 2;
    localparam int S_HT  = SH + SFP + SSY + SBP;
    localparam int S_VT  = SV + SFP + SSY + SBP;
    localparam int S_FT  = S_HT * S_VT;
    localparam int S_XL  = SH / 8;
    localparam int S_LIM = (SH / 8) * (SV / 8);
    localparam int L_HT  = 1688;
    localparam int L_HV  = 1280;
    localparam int L_XL  = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_n_l;
    logic [1:0]  addr_init_s, addr_read_s;
    logic [7:0]  char_read_s, font_row_s;
    logic [10:0] font_addr_s;
    logic        pixel_s, de_s, hsync_s, vsync_s, fs_s;
    logic [14:0] addr_init_l, addr_read_l;
    logic [7:0]  char_read_l, font_row_l;
    logic [10:0] font_addr_l;
    logic        pixel_l, de_l, hsync_l, vsync_l, fs_l;

    logic [7:0] mem_s [0:3];
    logic [7:0] rom [0:2047];

    assign char_read_s = mem_s[addr_read_s];
    assign font_row_s  = rom[font_addr_s];
    assign char_read_l = addr_read_l[7:0] ^ 8'h5a;
    assign font_row_l  = rom[font_addr_l];

    vga_text_scanout #(
        .h_disp(SH), .h_front(SFP), .h_sync(SSY), .h_back(SBP),
        .v_disp(SV), .v_front(SFP), .v_sync(SSY), .v_back(SBP)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .addr_init(addr_init_s), .addr_read(addr_read_s),
        .char_read(char_read_s), .font_addr(font_addr_s), .font_row(font_row_s),
        .pixel(pixel_s), .de(de_s), .hsync(hsync_s), .vsync(vsync_s), .frame_start(fs_s)
    );

    vga_text_scanout dut_l (
        .clk(clk), .rst_n(rst_n_l), .addr_init(addr_init_l), .addr_read(addr_read_l),
        .char_read(char_read_l), .font_addr(font_addr_l), .font_row(font_row_l),
        .pixel(pixel_l), .de(de_l), .hsync(hsync_l), .vsync(vsync_l), .frame_start(fs_l)
    );

    int checks = 0;
    int errors = 0;

    // Model state: q is the index of the cycle the counters are currently in since reset release.
    int         q;
    int         frame_org [0:31];
    logic [1:0] last_addr;
    int         hs_cnt;
    int         fs_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] exp_addr_s(input int x, input int y, input int org);
        return 2'((org + (y / 8) * S_XL + x / 8) % S_LIM);
    endfunction

    function automatic logic exp_pix_s(input int x, input int y, input int org);
        logic [7:0] c;
        logic [7:0] g;
        if (x >= SH || y >= SV) return 1'b0;
        c = mem_s[exp_addr_s(x, y, org)];
        g = rom[{c, 3'(y % 8)}];
        return g[7 - (x % 8)];
    endfunction

    task automatic model_reset();
        q         = 0;
        last_addr = '0;
        hs_cnt    = 0;
        fs_prev   = -1;
        for (int i = 0; i < 32; i++) frame_org[i] = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pixel"}, 32'(pixel_s), 32'd0);
        check({tag, "_de"}, 32'(de_s), 32'd0);
        check({tag, "_hsync"}, 32'(hsync_s), 32'd0);
        check({tag, "_vsync"}, 32'(vsync_s), 32'd0);
        check({tag, "_fstart"}, 32'(fs_s), 32'd0);
        check({tag, "_addr"}, 32'(addr_read_s), 32'd0);
        check({tag, "_font_addr"}, 32'(font_addr_s), 32'd0);
    endtask

    // Advance one clock on the small instance and compare every output with the model.
    task automatic step();
        int   xa, ya, xo, yo, org;
        logic e_de, e_hs, e_vs, e_fs, e_px;
        xo = 0; yo = 0; org = 0;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_px = 1'b0;
        if ((q % S_HT) == S_HT - 1 && ((q / S_HT) % S_VT) == S_VT - 1)
            frame_org[q / S_FT + 1] = int'(addr_init_s);
        @(posedge clk);
        #1;
        q++;
        xa = (q - 1) % S_HT;
        ya = ((q - 1) / S_HT) % S_VT;
        if (xa < SH && ya < SV) last_addr = exp_addr_s(xa, ya, frame_org[(q - 1) / S_FT]);
        check("addr_read", 32'(addr_read_s), 32'(last_addr));
        if (q >= 3) begin
            xo   = (q - 3) % S_HT;
            yo   = ((q - 3) / S_HT) % S_VT;
            org  = frame_org[(q - 3) / S_FT];
            e_de = (xo < SH) && (yo < SV);
            e_hs = (xo >= SH + SFP) && (xo < SH + SFP + SSY);
            e_vs = (yo >= SV + SFP) && (yo < SV + SFP + SSY);
            e_fs = (xo == 0) && (yo == 0);
            e_px = exp_pix_s(xo, yo, org);
        end
        check("pixel", 32'(pixel_s), 32'(e_px));
        check("de", 32'(de_s), 32'(e_de));
        check("hsync", 32'(hsync_s), 32'(e_hs));
        check("vsync", 32'(vsync_s), 32'(e_vs));
        check("frame_start", 32'(fs_s), 32'(e_fs));
        if (q >= 3) begin
            hs_cnt += int'(hsync_s);
            if (xo == S_HT - 1) begin
                check("hsync_width", 32'(hs_cnt), 32'd2);
                hs_cnt = 0;
            end
        end
        if (fs_s === 1'b1) begin
            if (fs_prev >= 0) check("frame_period", 32'(q - fs_prev), 32'(S_FT));
            fs_prev = q;
        end
    endtask

    task automatic run_to(input int target);
        while (q < target) step();
    endtask

    task automatic scramble();
        for (int i = 0; i < 4; i++) mem_s[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    endtask

    initial begin
        int de_cnt, hsl_cnt, fs_cnt, xo, yo;
        logic [7:0] g;

        rst_n = 1'b0;
        rst_n_l = 1'b0;
        addr_init_s = '0;
        addr_init_l = '0;
        for (int i = 0; i < 4; i++) mem_s[i] = 8'(i);
        for (int i = 0; i < 2048; i++) rom[i] = 8'h81;
        #1;
        check_zero("reset");
        $display("step 1: reset state");

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_zero("release");
        step();
        step();
        step();
        check("first_pixel", 32'(pixel_s), 32'd1);
        check("first_fstart", 32'(fs_s), 32'd1);
        check("first_de", 32'(de_s), 32'd1);
        $display("step 2: first pixel at 3 clocks, glyph 8'h81");

        run_to(8 * S_HT + 1);
        check("line8_first_addr", 32'(addr_read_s), 32'd2);
        $display("step 3: line 8 starts at cell 2");

        run_to(250);
        addr_init_s = 2'd2;
        run_to(S_FT + 1);
        check("next_frame_origin", 32'(addr_read_s), 32'd2);
        $display("step 4: mid-frame origin change applied next frame");

        run_to(S_FT + 18 * S_HT);
        scramble();
        addr_init_s = 2'd3;
        run_to(2 * S_FT + 1);
        check("wrap_cell0", 32'(addr_read_s), 32'd3);
        run_to(2 * S_FT + 9);
        check("wrap_cell1", 32'(addr_read_s), 32'd0);
        run_to(2 * S_FT + 8 * S_HT + 1);
        check("wrap_cell2", 32'(addr_read_s), 32'd1);
        run_to(2 * S_FT + 8 * S_HT + 9);
        check("wrap_cell3", 32'(addr_read_s), 32'd2);
        $display("step 5: origin 3 reads cells 3,0,1,2");

        for (int f = 2; f < 5; f++) begin
            run_to(f * S_FT + 18 * S_HT);
            scramble();
            addr_init_s = 2'($urandom_range(0, 3));
            $display("step 6.%0d: random text/font, next origin %0d", f, addr_init_s);
        end

        run_to(5 * S_FT + 9 * S_HT + 5);
        check("pre_reset_de", 32'(de_s), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_zero("rerelease");
        step();
        step();
        step();
        check("restart_fstart", 32'(fs_s), 32'd1);
        run_to(S_FT + 30);
        $display("step 7: mid-line reset at (5,9) and restart");

        de_cnt = 0;
        hsl_cnt = 0;
        fs_cnt = 0;
        @(negedge clk);
        rst_n_l = 1'b1;
        for (int k = 1; k <= 3 * L_HT + 2; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) begin
                check("big_idle_de", 32'(de_l), 32'd0);
                check("big_idle_fstart", 32'(fs_l), 32'd0);
            end else begin
                xo = (k - 3) % L_HT;
                yo = (k - 3) / L_HT;
                if (k == 3) check("big_first_fstart", 32'(fs_l), 32'd1);
                check("big_de", 32'(de_l), 32'(xo < L_HV));
                if (xo < L_HV) begin
                    g = rom[{8'(((yo / 8) * L_XL + xo / 8) % 256) ^ 8'h5a, 3'(yo % 8)}];
                    check("big_pixel", 32'(pixel_l), 32'(g[7 - (xo % 8)]));
                end else begin
                    check("big_blank_pixel", 32'(pixel_l), 32'd0);
                end
                check("big_vsync", 32'(vsync_l), 32'd0);
                de_cnt  += int'(de_l);
                hsl_cnt += int'(hsync_l);
                fs_cnt  += int'(fs_l);
                if (xo == L_HT - 1) begin
                    check("big_de_per_line", 32'(de_cnt), 32'(L_HV));
                    check("big_hsync_width", 32'(hsl_cnt), 32'd112);
                    $display("step 8.%0d: 1280x1024 line %0d de=%0d hsync=%0d", yo, yo, de_cnt, hsl_cnt);
                    de_cnt = 0;
                    hsl_cnt = 0;
                end
            end
        end
        check("big_fstart_count", 32'(fs_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
